// File: rtl/param_mem.sv
`timescale 1ns/1ps
// param_mem: single-port synchronous scratch memory with configurable width,
// depth and read latency, four write modes and a ready/valid request port.
// A clear sequencer zeroes the whole array after reset or on clr_start.
// Optional build macro PARAM_MEM_PARITY_EN adds a stored even-parity bit per
// word and the rd_perr output.
module param_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr_start,
  output logic              busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              addr_err
`ifdef PARAM_MEM_PARITY_EN
  ,
  output logic              rd_perr
`endif
);

  typedef enum logic {CLEAR, IDLE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

  state_t state, state_nxt;
  logic [ADDR_W-1:0] ptr;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept, rd_accept, wr_accept, in_range;
  logic [DATA_W-1:0] old_word, wr_word, rd_word;

  logic [RD_LAT-1:0] pipe_v;
  logic [DATA_W-1:0] pipe_d [RD_LAT];

`ifdef PARAM_MEM_PARITY_EN
  logic              mem_par [DEPTH];
  logic              rd_perr_word;
  logic [RD_LAT-1:0] pipe_p;
`endif

  assign accept    = req_valid & req_ready;
  assign rd_accept = accept & ~req_wr;
  assign wr_accept = accept & req_wr;
  assign in_range  = ({1'b0, addr} < DEPTH_X);

  // State register: reset always lands in CLEAR so the array gets swept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR;
    else        state <= state_nxt;
  end

  // Next state: sweep ends after the last word; clr_start only counts in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (ptr == LAST_ADDR) state_nxt = IDLE;
      IDLE:    if (clr_start)        state_nxt = CLEAR;
      default:                       state_nxt = CLEAR;
    endcase
  end

  // Outputs: clr_start blocks acceptance in the same cycle so the clear wins.
  always_comb begin
    busy      = (state == CLEAR);
    req_ready = (state == IDLE) && !clr_start;
  end

  // Clear pointer walks 0..DEPTH-1 during CLEAR and rests at 0 otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 ptr <= '0;
    else if (state == CLEAR && ptr != LAST_ADDR) ptr <= ptr + ADDR_W'(1);
    else                                        ptr <= '0;
  end

  // Read-modify-write operand and read sample; out-of-range addresses read 0.
  always_comb begin
    old_word = in_range ? mem[addr] : '0;
    rd_word  = old_word;
    case (req_mode)
      2'b00:   wr_word = data_in;
      2'b01:   wr_word = old_word ^ data_in;
      2'b10:   wr_word = old_word | data_in;
      default: wr_word = old_word & data_in;
    endcase
`ifdef PARAM_MEM_PARITY_EN
    rd_perr_word = in_range ? ((^mem[addr]) ^ mem_par[addr]) : 1'b0;
`endif
  end

  // Array write port: the sweep owns it in CLEAR, accepted writes in IDLE.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[ptr] <= '0;
`ifdef PARAM_MEM_PARITY_EN
      mem_par[ptr] <= 1'b0;
`endif
    end else if (wr_accept && in_range) begin
      mem[addr] <= wr_word;
`ifdef PARAM_MEM_PARITY_EN
      mem_par[addr] <= ^wr_word;
`endif
    end
  end

  // Read pipeline: data stages only load behind a valid, so data_out holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_d[i] <= '0;
`ifdef PARAM_MEM_PARITY_EN
      pipe_p <= '0;
`endif
    end else begin
      pipe_v[0] <= rd_accept;
      if (rd_accept) begin
        pipe_d[0] <= rd_word;
`ifdef PARAM_MEM_PARITY_EN
        pipe_p[0] <= rd_perr_word;
`endif
      end
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) begin
          pipe_d[i] <= pipe_d[i-1];
`ifdef PARAM_MEM_PARITY_EN
          pipe_p[i] <= pipe_p[i-1];
`endif
        end
      end
    end
  end

  // Address error flag pulses the cycle after an out-of-range accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_err <= 1'b0;
    else        addr_err <= accept & ~in_range;
  end

  assign rd_valid = pipe_v[RD_LAT-1];
  assign data_out = pipe_d[RD_LAT-1];
`ifdef PARAM_MEM_PARITY_EN
  assign rd_perr  = pipe_v[RD_LAT-1] & pipe_p[RD_LAT-1];
`endif

endmodule

// File: tb/tb_param_mem.sv
`timescale 1ns/1ps
// Self-checking bench for param_mem: one default instance (DEPTH 32, RD_LAT 1)
// and one with DEPTH 20, RD_LAT 3, both driven by the same request stream.
module tb_param_mem;

  logic       clk = 1'b0;
  logic       rst_n, req_valid, req_wr, clr_start;
  logic [1:0] req_mode;
  logic [4:0] addr;
  logic [7:0] data_in;

  logic       req_ready_a, busy_a, rd_valid_a, addr_err_a;
  logic       req_ready_b, busy_b, rd_valid_b, addr_err_b;
  logic [7:0] data_out_a, data_out_b;
`ifdef PARAM_MEM_PARITY_EN
  logic       rd_perr_a, rd_perr_b;
`endif

  int check_cnt = 0;
  int pass_cnt  = 0;
  int cyc       = 0;
  int viol      = 0;
  int err_a, err_b, perr_a, perr_b;
  logic [7:0] got_a[$], got_b[$];
  int         tim_a[$], tim_b[$];

  always #5 clk = ~clk;

  param_mem u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_a),
    .req_wr(req_wr), .req_mode(req_mode), .addr(addr), .data_in(data_in),
    .clr_start(clr_start), .busy(busy_a), .rd_valid(rd_valid_a),
    .data_out(data_out_a), .addr_err(addr_err_a)
`ifdef PARAM_MEM_PARITY_EN
    , .rd_perr(rd_perr_a)
`endif
  );

  param_mem #(.DATA_W(8), .DEPTH(20), .RD_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_b),
    .req_wr(req_wr), .req_mode(req_mode), .addr(addr), .data_in(data_in),
    .clr_start(clr_start), .busy(busy_b), .rd_valid(rd_valid_b),
    .data_out(data_out_b), .addr_err(addr_err_b)
`ifdef PARAM_MEM_PARITY_EN
    , .rd_perr(rd_perr_b)
`endif
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Drive one cycle of inputs, clock it, then log what both instances show.
  task automatic applyStimulus(input logic v, input logic wr, input logic [1:0] mode,
                               input logic [4:0] a, input logic [7:0] d, input logic clr);
    req_valid = v; req_wr = wr; req_mode = mode; addr = a; data_in = d; clr_start = clr;
    @(posedge clk); #1;
    cyc++;
    if (rd_valid_a) begin got_a.push_back(data_out_a); tim_a.push_back(cyc); end
    if (rd_valid_b) begin got_b.push_back(data_out_b); tim_b.push_back(cyc); end
    if (addr_err_a) err_a++;
    if (addr_err_b) err_b++;
`ifdef PARAM_MEM_PARITY_EN
    if (rd_perr_a) perr_a++;
    if (rd_perr_b) perr_b++;
`endif
  endtask

  task automatic clearLog();
    got_a.delete(); got_b.delete(); tim_a.delete(); tim_b.delete();
    err_a = 0; err_b = 0; perr_a = 0; perr_b = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 2'b00, 5'd0, 8'h00, 1'b0);
  endtask

  task automatic doWrite(input logic [4:0] a, input logic [7:0] d, input logic [1:0] mode);
    applyStimulus(1'b1, 1'b1, mode, a, d, 1'b0);
  endtask

  // Measure edges from now until busy drops on each instance (0 = never).
  task automatic sweepLength(input logic hold_valid, output int len_a, output int len_b);
    len_a = 0; len_b = 0;
    for (int i = 1; i <= 100 && (len_a == 0 || len_b == 0); i++) begin
      applyStimulus(hold_valid, 1'b0, 2'b00, 5'd0, 8'h00, 1'b0);
      if (busy_a && req_ready_a) viol++;
      if (busy_b && req_ready_b) viol++;
      if (!busy_a && len_a == 0) len_a = i;
      if (!busy_b && len_b == 0) len_b = i;
    end
  endtask

  // Back-to-back reads; checks count, latency, gap-free delivery and data.
  task automatic checkReads(input string tag, input int addrs[$],
                            input logic [7:0] ea[$], input logic [7:0] eb[$]);
    int k, gaps_a, gaps_b;
    clearLog();
    k = cyc + 1;
    foreach (addrs[i]) applyStimulus(1'b1, 1'b0, 2'b00, 5'(addrs[i]), 8'h00, 1'b0);
    idle(5);
    checkOutput({tag, "_cnt_a"}, got_a.size(), ea.size());
    checkOutput({tag, "_cnt_b"}, got_b.size(), eb.size());
    if (tim_a.size() > 0) checkOutput({tag, "_lat_a"}, tim_a[0] - k + 1, 1);
    if (tim_b.size() > 0) checkOutput({tag, "_lat_b"}, tim_b[0] - k + 1, 3);
    gaps_a = 0; gaps_b = 0;
    for (int i = 1; i < tim_a.size(); i++) if (tim_a[i] != tim_a[i-1] + 1) gaps_a++;
    for (int i = 1; i < tim_b.size(); i++) if (tim_b[i] != tim_b[i-1] + 1) gaps_b++;
    if (addrs.size() > 1) begin
      checkOutput({tag, "_gaps_a"}, gaps_a, 0);
      checkOutput({tag, "_gaps_b"}, gaps_b, 0);
    end
    for (int i = 0; i < ea.size() && i < got_a.size(); i++)
      checkOutput($sformatf("%s_data_a[%0d]", tag, i), got_a[i], ea[i]);
    for (int i = 0; i < eb.size() && i < got_b.size(); i++)
      checkOutput($sformatf("%s_data_b[%0d]", tag, i), got_b[i], eb[i]);
  endtask

  // Hard stop in case something hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int la, lb, bc_a, bc_b;
    int al[$];
    logic [7:0] ea[$], eb[$];

    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_mode = 2'b00;
    addr = 5'd0; data_in = 8'h00; clr_start = 1'b0;
    clearLog();

    // Reset values while a request is being offered
    repeat (3) applyStimulus(1'b1, 1'b0, 2'b00, 5'd0, 8'h00, 1'b0);
    checkOutput("rst_ready_a", req_ready_a, 0);
    checkOutput("rst_busy_a",  busy_a, 1);
    checkOutput("rst_rdv_a",   rd_valid_a, 0);
    checkOutput("rst_dout_a",  data_out_a, 0);
    checkOutput("rst_err_a",   addr_err_a, 0);
    checkOutput("rst_ready_b", req_ready_b, 0);
    checkOutput("rst_busy_b",  busy_b, 1);
    checkOutput("rst_dout_b",  data_out_b, 0);

    // Power-on sweep lasts DEPTH cycles with requests held
    rst_n = 1'b1;
    sweepLength(1'b1, la, lb);
    checkOutput("sweep_len_a", la, 32);
    checkOutput("sweep_len_b", lb, 20);
    checkOutput("sweep_ready_viol", viol, 0);
    idle(5);

    // Every address reads 0 after the sweep; 20..31 are out of range on b
    al.delete(); ea.delete();
    for (int i = 0; i < 32; i++) begin al.push_back(i); ea.push_back(8'h00); end
    checkReads("clr_all", al, ea, ea);
    checkOutput("clr_all_err_a", err_a, 0);
    checkOutput("clr_all_err_b", err_b, 12);

    // Write-mode chain on addr 5: A5 ^FF=5A |0F=5F &3C=1C
    clearLog();
    doWrite(5'd5, 8'hA5, 2'b00);
    doWrite(5'd5, 8'hFF, 2'b01);
    doWrite(5'd5, 8'h0F, 2'b10);
    doWrite(5'd5, 8'h3C, 2'b11);
    checkOutput("mode_err_b", err_b, 0);
    checkReads("modes", '{5}, '{8'h1C}, '{8'h1C});

    // Write then immediate read of same address, then a burst of 0..7
    doWrite(5'd3, 8'h11, 2'b00);
    al = '{3, 0, 1, 2, 3, 4, 5, 6, 7};
    ea = '{8'h11, 8'h00, 8'h00, 8'h00, 8'h11, 8'h00, 8'h1C, 8'h00, 8'h00};
    checkReads("b2b", al, ea, ea);

    // Out-of-range on b (addr 25), in range on a
    clearLog();
    doWrite(5'd25, 8'h55, 2'b00);
    idle(2);
    checkOutput("oor_wr_err_a", err_a, 0);
    checkOutput("oor_wr_err_b", err_b, 1);
    checkReads("oor_rd", '{25}, '{8'h55}, '{8'h00});
    checkOutput("oor_rd_err_a", err_a, 0);
    checkOutput("oor_rd_err_b", err_b, 1);
    al.delete(); ea.delete();
    for (int i = 0; i < 20; i++) begin
      al.push_back(i);
      ea.push_back(i == 3 ? 8'h11 : (i == 5 ? 8'h1C : 8'h00));
    end
    checkReads("oor_keep", al, ea, ea);

    // clr_start beats a simultaneous request; in-flight read still completes
    clearLog();
    doWrite(5'd9, 8'h77, 2'b00);
    applyStimulus(1'b1, 1'b0, 2'b00, 5'd3, 8'h00, 1'b0);
    req_valid = 1'b1; req_wr = 1'b1; addr = 5'd9; data_in = 8'h33; clr_start = 1'b1;
    #1;
    checkOutput("clr_ready_a", req_ready_a, 0);
    checkOutput("clr_ready_b", req_ready_b, 0);
    applyStimulus(1'b1, 1'b1, 2'b00, 5'd9, 8'h33, 1'b1);
    bc_a = 0; bc_b = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy_a) bc_a++;
      if (busy_b) bc_b++;
      applyStimulus(1'b0, 1'b0, 2'b00, 5'd0, 8'h00, i == 4);
    end
    checkOutput("clr_busy_a", bc_a, 32);
    checkOutput("clr_busy_b", bc_b, 20);
    checkOutput("inflight_cnt_a", got_a.size(), 1);
    checkOutput("inflight_cnt_b", got_b.size(), 1);
    if (got_b.size() > 0) checkOutput("inflight_data_b", got_b[0], 8'h11);
    checkReads("clr_addr9", '{9}, '{8'h00}, '{8'h00});

    // Reset during an in-flight read, then reset again mid-sweep
    applyStimulus(1'b1, 1'b0, 2'b00, 5'd5, 8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_rdv_a",  rd_valid_a, 0);
    checkOutput("mid_rst_dout_b", data_out_b, 0);
    checkOutput("mid_rst_busy_b", busy_b, 1);
    clearLog();
    idle(3);
    rst_n = 1'b1;
    idle(10);
    checkOutput("drop_rdv_a", got_a.size(), 0);
    checkOutput("drop_rdv_b", got_b.size(), 0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    sweepLength(1'b0, la, lb);
    checkOutput("resweep_len_a", la, 32);
    checkOutput("resweep_len_b", lb, 20);
    checkReads("resweep", '{3, 5, 9}, '{8'h00, 8'h00, 8'h00}, '{8'h00, 8'h00, 8'h00});

`ifdef PARAM_MEM_PARITY_EN
    // Corrupt the stored parity of addr 2 on instance a only
    u_a.mem_par[2] = ~u_a.mem_par[2];
    checkReads("parity", '{2}, '{8'h00}, '{8'h00});
    checkOutput("perr_a", perr_a, 1);
    checkOutput("perr_b", perr_b, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
